// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the fetch stage: opcodes, fetch FSM states and
// instruction field slices used by the IF/ID hazard decode.
package fetch_stage_pkg;

  localparam logic [3:0] OPC_B   = 4'hC;
  localparam logic [3:0] OPC_BR  = 4'hD;
  localparam logic [3:0] OPC_SW  = 4'h9;
  localparam logic [3:0] OPC_HLT = 4'hF;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2,
    HALT  = 2'd3
  } fetch_state_t;

  function automatic logic [3:0] opcode_of(input logic [15:0] instr);
    return instr[15:12];
  endfunction

  function automatic logic [3:0] rs_of(input logic [15:0] instr);
    return instr[7:4];
  endfunction

  // Stores name their data register in the rt slot at [11:8].
  function automatic logic [3:0] rt_of(input logic [15:0] instr);
    return (instr[15:12] == OPC_SW) ? instr[11:8] : instr[3:0];
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request bus: req/addr held until rdy completes the fetch.
interface fetch_stage_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
);
  logic               req;
  logic [PC_W-1:0]    addr;
  logic               rdy;
  logic [INSTR_W-1:0] data;

  modport master (output req, output addr, input rdy, input data);
  modport slave  (input req, input addr, output rdy, output data);
endinterface

// File: rtl/fetch_stage_if_id.sv
// IF/ID pipeline register with load/bubble/hold control and the hazard-field
// decode consumed by the hazard-detection unit.
module if_id_reg
  import fetch_stage_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               bubble,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc_plus2_in,
  output logic               valid,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc_plus2,
  output logic [3:0]         rs,
  output logic [3:0]         rt,
  output logic               branch,
  output logic               mem_write
);

  // Neither load nor bubble means hold; pc_plus2 is left alone on a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid    <= 1'b0;
      instr    <= '0;
      pc_plus2 <= '0;
    end else if (load) begin
      valid    <= 1'b1;
      instr    <= instr_in;
      pc_plus2 <= pc_plus2_in;
    end else if (bubble) begin
      valid <= 1'b0;
      instr <= '0;
    end
  end

  assign rs        = rs_of(instr);
  assign rt        = rt_of(instr);
  assign branch    = valid && (opcode_of(instr) == OPC_B || opcode_of(instr) == OPC_BR);
  assign mem_write = valid && (opcode_of(instr) == OPC_SW);

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, fetch FSM and single-entry skid buffer feeding the IF/ID register.
//   state | meaning
//   FETCH | request outstanding at pc
//   HOLD  | response parked in skid buffer until stalls release; no request
//   DRAIN | redirected while a request was outstanding; response will be dropped
//   HALT  | HLT reached IF/ID; no further requests until reset
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [3:0]      HLT_OPC  = OPC_HLT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_to_stall,
  input  logic               brstall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  fetch_stage_if.master      imem,
  output logic               if_id_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc_plus2,
  output logic [3:0]         if_id_rs,
  output logic [3:0]         if_id_rt,
  output logic               if_id_branch,
  output logic               if_id_memWrite,
  output logic               halted
);

  fetch_state_t       state, state_nxt;
  logic [PC_W-1:0]    pc, pc_nxt;
  logic [PC_W-1:0]    req_addr, req_addr_nxt;
  logic [INSTR_W-1:0] skid_instr, skid_instr_nxt;
  logic [PC_W-1:0]    skid_pc2, skid_pc2_nxt;
  logic               halted_nxt;
  logic               req_int, xfer;
  logic [PC_W-1:0]    pc_plus2;
  logic               id_load, id_bubble;
  logic [INSTR_W-1:0] id_instr_in;
  logic [PC_W-1:0]    id_pc2_in;

  assign req_int   = (state == FETCH) || (state == DRAIN);
  assign xfer      = req_int && imem.rdy;
  assign pc_plus2  = pc + PC_W'(2);
  // Reset gates req combinationally so an in-flight fetch is abandoned at once.
  assign imem.req  = req_int && rst_n;
  assign imem.addr = (state == DRAIN) ? req_addr : pc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH;
      pc         <= RESET_PC;
      req_addr   <= RESET_PC;
      skid_instr <= '0;
      skid_pc2   <= '0;
      halted     <= 1'b0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      req_addr   <= req_addr_nxt;
      skid_instr <= skid_instr_nxt;
      skid_pc2   <= skid_pc2_nxt;
      halted     <= halted_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    req_addr_nxt   = req_addr;
    skid_instr_nxt = skid_instr;
    skid_pc2_nxt   = skid_pc2;
    halted_nxt     = halted;
    id_load        = 1'b0;
    id_bubble      = 1'b0;
    id_instr_in    = imem.data;
    id_pc2_in      = pc_plus2;
    case (state)
      FETCH: begin
        if (branch_taken) begin
          id_bubble      = 1'b1;
          pc_nxt         = branch_target;
          skid_instr_nxt = '0;
          skid_pc2_nxt   = '0;
          if (!xfer) begin
            req_addr_nxt = pc;
            state_nxt    = DRAIN;
          end
        end else if (load_to_stall || brstall) begin
          id_bubble = !load_to_stall;
          if (xfer) begin
            skid_instr_nxt = imem.data;
            skid_pc2_nxt   = pc_plus2;
            state_nxt      = HOLD;
          end
        end else if (xfer) begin
          id_load = 1'b1;
          pc_nxt  = pc_plus2;
          if (opcode_of(imem.data) == HLT_OPC) begin
            state_nxt  = HALT;
            halted_nxt = 1'b1;
          end
        end else begin
          id_bubble = 1'b1;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          id_bubble      = 1'b1;
          pc_nxt         = branch_target;
          skid_instr_nxt = '0;
          skid_pc2_nxt   = '0;
          state_nxt      = FETCH;
        end else if (load_to_stall || brstall) begin
          id_bubble = !load_to_stall;
        end else begin
          id_load     = 1'b1;
          id_instr_in = skid_instr;
          id_pc2_in   = skid_pc2;
          pc_nxt      = skid_pc2;
          if (opcode_of(skid_instr) == HLT_OPC) begin
            state_nxt  = HALT;
            halted_nxt = 1'b1;
          end else begin
            state_nxt = FETCH;
          end
        end
      end
      DRAIN: begin
        id_bubble = branch_taken || !load_to_stall;
        if (branch_taken) pc_nxt = branch_target;
        if (xfer) state_nxt = FETCH;
      end
      HALT: begin
        id_bubble = branch_taken || !load_to_stall;
      end
      default: state_nxt = FETCH;
    endcase
  end

  if_id_reg #(.PC_W(PC_W), .INSTR_W(INSTR_W)) u_if_id (
    .clk         (clk),
    .rst_n       (rst_n),
    .load        (id_load),
    .bubble      (id_bubble),
    .instr_in    (id_instr_in),
    .pc_plus2_in (id_pc2_in),
    .valid       (if_id_valid),
    .instr       (if_id_instr),
    .pc_plus2    (if_id_pc_plus2),
    .rs          (if_id_rs),
    .rt          (if_id_rt),
    .branch      (if_id_branch),
    .mem_write   (if_id_memWrite)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: latency-programmable memory model plus an
// in-order scoreboard of instructions expected to reach IF/ID.
module tb_fetch_stage;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc2;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        load_to_stall = 1'b0;
  logic        brstall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic        if_id_valid;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_plus2;
  logic [3:0]  if_id_rs;
  logic [3:0]  if_id_rt;
  logic        if_id_branch;
  logic        if_id_memWrite;
  logic        halted;

  fetch_stage_if #(.PC_W(16), .INSTR_W(16)) imem_bus ();

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .load_to_stall  (load_to_stall),
    .brstall        (brstall),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem           (imem_bus.master),
    .if_id_valid    (if_id_valid),
    .if_id_instr    (if_id_instr),
    .if_id_pc_plus2 (if_id_pc_plus2),
    .if_id_rs       (if_id_rs),
    .if_id_rt       (if_id_rt),
    .if_id_branch   (if_id_branch),
    .if_id_memWrite (if_id_memWrite),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  sb_t         sb[$];
  sb_t         last;
  logic        prev_lts = 1'b0;
  logic        halted_exp = 1'b0;
  logic        draining = 1'b0;
  logic        xfer_prev = 1'b0;
  logic        idle_rdy = 1'b1;
  int          wait_cnt = 0;
  int          lat = 0;
  int          valid_seen = 0;
  int          vs0;
  logic [15:0] mem [256];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic drive_mem();
    if (imem_bus.req) begin
      if (wait_cnt >= lat) begin
        imem_bus.rdy  = 1'b1;
        imem_bus.data = mem[imem_bus.addr[8:1]];
      end else begin
        imem_bus.rdy  = 1'b0;
        imem_bus.data = 16'hDEAD;
      end
    end else begin
      imem_bus.rdy  = idle_rdy;
      imem_bus.data = 16'hD0D0;
    end
  endtask

  task automatic check_ifid();
    logic [3:0] opc;
    if (if_id_valid) begin
      valid_seen++;
      if (prev_lts) begin
        chk("held_instr", 32'(if_id_instr), 32'(last.instr));
        chk("held_pc2", 32'(if_id_pc_plus2), 32'(last.pc2));
      end else if (sb.size() == 0) begin
        chk("unexpected_valid", 32'(if_id_valid), 0);
      end else begin
        last = sb.pop_front();
        opc  = last.instr[15:12];
        chk("sb_instr", 32'(if_id_instr), 32'(last.instr));
        chk("sb_pc2", 32'(if_id_pc_plus2), 32'(last.pc2));
        chk("sb_rs", 32'(if_id_rs), 32'(last.instr[7:4]));
        chk("sb_rt", 32'(if_id_rt), (opc == 4'h9) ? 32'(last.instr[11:8]) : 32'(last.instr[3:0]));
        chk("sb_branch", 32'(if_id_branch), 32'(opc == 4'hC || opc == 4'hD));
        chk("sb_memwrite", 32'(if_id_memWrite), 32'(opc == 4'h9));
        if (opc == 4'hF) halted_exp = 1'b1;
      end
    end else begin
      chk("bubble_instr", 32'(if_id_instr), 0);
      chk("bubble_branch", 32'(if_id_branch), 0);
      chk("bubble_memwrite", 32'(if_id_memWrite), 0);
    end
    chk("halted", 32'(halted), 32'(halted_exp));
    if (halted_exp) chk("halt_req", 32'(imem_bus.req), 0);
  endtask

  // One clock: check/score at negedge, then advance and drive memory at posedge+1.
  task automatic tick();
    @(negedge clk);
    check_ifid();
    prev_lts = load_to_stall && !branch_taken;
    if (branch_taken) sb.delete();
    xfer_prev = imem_bus.req && imem_bus.rdy;
    if (xfer_prev) begin
      if (!branch_taken && !draining)
        sb.push_back({imem_bus.data, imem_bus.addr + 16'd2});
      draining = 1'b0;
    end else if (imem_bus.req && branch_taken) begin
      draining = 1'b1;
    end
    @(posedge clk);
    #1;
    if (xfer_prev || !imem_bus.req) wait_cnt = 0;
    else wait_cnt++;
    drive_mem();
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    load_to_stall = 1'b0;
    brstall       = 1'b0;
    branch_taken  = 1'b0;
    #1;
    chk("rst_req", 32'(imem_bus.req), 0);
    chk("rst_addr", 32'(imem_bus.addr), 0);
    chk("rst_valid", 32'(if_id_valid), 0);
    chk("rst_instr", 32'(if_id_instr), 0);
    chk("rst_pc2", 32'(if_id_pc_plus2), 0);
    chk("rst_halted", 32'(halted), 0);
    sb.delete();
    halted_exp = 1'b0;
    draining   = 1'b0;
    prev_lts   = 1'b0;
    wait_cnt   = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    drive_mem();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h1000 | 16'(i * 2);
    mem[3]    = 16'h1234;
    mem[8]    = 16'hF010;
    mem[8'h21] = 16'hC123;
    mem[255]  = 16'h9A5B;
    imem_bus.rdy  = 1'b0;
    imem_bus.data = 16'h0000;
    #1;

    // zero-latency streaming
    lat = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      chk("zl_addr", 32'(imem_bus.addr), 32'(2 * i));
      chk("zl_req", 32'(imem_bus.req), 1);
      chk("zl_valid", 32'(if_id_valid), 32'(i > 0));
      if (i > 0) chk("zl_pc2", 32'(if_id_pc_plus2), 32'(2 * i));
      tick();
    end

    // multi-cycle latency: address held, one instruction per request
    lat = 3;
    drive_mem();
    for (int k = 0; k < 4; k++) begin
      chk("lat_addr_hold", 32'(imem_bus.addr), 32'h8);
      chk("lat_req_hold", 32'(imem_bus.req), 1);
      tick();
    end
    chk("lat_next_addr", 32'(imem_bus.addr), 32'hA);
    vs0 = valid_seen;
    for (int k = 0; k < 4; k++) tick();
    chk("lat_valid_rate", 32'(valid_seen - vs0), 1);
    chk("lat_addr_after", 32'(imem_bus.addr), 32'hC);

    // load-use stall with a response landing in the skid buffer
    lat = 0;
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    chk("lts_addr", 32'(imem_bus.addr), 32'h6);
    load_to_stall = 1'b1;
    tick();
    chk("lts_req_off", 32'(imem_bus.req), 0);
    tick();
    chk("lts_frozen", 32'(if_id_instr), 32'h1004);
    load_to_stall = 1'b0;
    tick();
    chk("lts_exit_instr", 32'(if_id_instr), 32'h1234);
    chk("lts_exit_pc2", 32'(if_id_pc_plus2), 32'h8);
    chk("lts_exit_valid", 32'(if_id_valid), 1);
    chk("lts_next_addr", 32'(imem_bus.addr), 32'h8);
    chk("lts_next_req", 32'(imem_bus.req), 1);
    tick();

    // redirect while a request is outstanding
    do_reset();
    for (int i = 0; i < 8; i++) tick();
    chk("br_pend_addr", 32'(imem_bus.addr), 32'h10);
    lat = 3;
    drive_mem();
    branch_taken  = 1'b1;
    branch_target = 16'h0040;
    tick();
    branch_taken = 1'b0;
    chk("br_flush_valid", 32'(if_id_valid), 0);
    for (int k = 0; k < 3; k++) begin
      chk("drain_addr", 32'(imem_bus.addr), 32'h10);
      chk("drain_req", 32'(imem_bus.req), 1);
      tick();
    end
    chk("br_target_addr", 32'(imem_bus.addr), 32'h40);
    chk("br_target_req", 32'(imem_bus.req), 1);
    chk("br_drop_valid", 32'(if_id_valid), 0);
    lat = 0;
    drive_mem();
    tick();
    chk("br_target_instr", 32'(if_id_instr), 32'h1040);

    // branch stall with a branch sitting in IF/ID
    tick();
    chk("bs_branch_flag", 32'(if_id_branch), 1);
    chk("bs_addr", 32'(imem_bus.addr), 32'h44);
    brstall = 1'b1;
    tick();
    brstall = 1'b0;
    chk("bs_bubble", 32'(if_id_valid), 0);
    chk("bs_req_off", 32'(imem_bus.req), 0);
    chk("bs_pc_hold", 32'(imem_bus.addr), 32'h44);
    tick();
    chk("bs_resume_instr", 32'(if_id_instr), 32'h1044);
    chk("bs_resume_pc2", 32'(if_id_pc_plus2), 32'h46);
    chk("bs_resume_addr", 32'(imem_bus.addr), 32'h46);

    // pc wrap at the top of the address space
    branch_taken  = 1'b1;
    branch_target = 16'hFFFE;
    tick();
    branch_taken = 1'b0;
    chk("wrap_addr", 32'(imem_bus.addr), 32'hFFFE);
    tick();
    chk("wrap_next_addr", 32'(imem_bus.addr), 32'h0000);
    chk("wrap_pc2", 32'(if_id_pc_plus2), 32'h0000);
    chk("wrap_memwrite", 32'(if_id_memWrite), 1);
    chk("wrap_rt", 32'(if_id_rt), 32'hA);
    tick();

    // HLT stops fetch and survives a later load-use hold
    mem[2] = 16'hF000;
    do_reset();
    for (int i = 0; i < 3; i++) tick();
    chk("hlt_halted", 32'(halted), 1);
    chk("hlt_req_off", 32'(imem_bus.req), 0);
    load_to_stall = 1'b1;
    tick();
    tick();
    load_to_stall = 1'b0;
    tick();
    chk("hlt_sticky", 32'(halted), 1);
    chk("hlt_still_off", 32'(imem_bus.req), 0);

    // taken branch in the HLT arrival cycle cancels the halt
    do_reset();
    tick();
    tick();
    chk("hltbr_addr", 32'(imem_bus.addr), 32'h4);
    branch_taken  = 1'b1;
    branch_target = 16'h0060;
    tick();
    branch_taken = 1'b0;
    chk("hltbr_halted", 32'(halted), 0);
    chk("hltbr_addr_tgt", 32'(imem_bus.addr), 32'h60);
    chk("hltbr_req", 32'(imem_bus.req), 1);
    chk("hltbr_valid", 32'(if_id_valid), 0);
    tick();
    tick();
    chk("hltbr_continue", 32'(halted), 0);
    chk("hltbr_instr", 32'(if_id_instr), 32'h1062);

    do_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the 16-bit, 16-register pipelined core; directly upstream of the hazard-detection unit.
- Holds the PC and issues requests to a variable-latency instruction memory using a req/rdy handshake.
- Delivers instructions and decoded hazard fields (rs, rt, branch, memWrite) to ID.
- Obeys load-use stall, branch stall and branch redirect; stops at HLT.

Parameters:
- PC_W, 16, PC and address width
- INSTR_W, 16, instruction width
- RESET_PC, 16'h0000, PC value after reset
- HLT_OPC, 4'hF, opcode that halts fetch

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- load_to_stall  in  1  hold PC and IF/ID contents (load-use)
- brstall  in  1  hold PC, load bubble into IF/ID
- branch_taken  in  1  ID resolved taken branch this cycle
- branch_target  in  PC_W  redirect address, valid with branch_taken
- imem_req  out  1  fetch request
- imem_addr  out  PC_W  fetch address
- imem_rdy  in  1  imem_data valid, request completes
- imem_data  in  INSTR_W  returned instruction
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_instr  out  INSTR_W  instruction in IF/ID (16'h0000 when bubble)
- if_id_pc_plus2  out  PC_W  address of instruction + 2
- if_id_rs  out  4  instr[7:4]
- if_id_rt  out  4  instr[11:8] when opcode==4'h9 (SW), else instr[3:0]
- if_id_branch  out  1  valid & opcode in {4'hC,4'hD}
- if_id_memWrite  out  1  valid & opcode==4'h9
- halted  out  1  HLT has entered IF/ID; fetch stopped

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - pc=RESET_PC, state=FETCH, buffer empty.
  - if_id_valid=0, if_id_instr=0, if_id_pc_plus2=0.
  - halted=0; imem_req forced 0 while rst_n=0.
- States:
  - FETCH: imem_req=1, imem_addr=pc.
  - HOLD: response buffered, waiting for stall release; no request.
  - DRAIN: redirect seen during an outstanding request; discard the response.
  - HALT: no request.
- Handshake:
  - Once raised, imem_req and imem_addr stay constant until a cycle with imem_rdy=1.
  - Transfer completes on imem_req & imem_rdy.
  - imem_rdy outside a request is ignored.
- Per-cycle priority: branch_taken > load_to_stall > brstall > normal.
- branch_taken:
  - if_id_valid<=0 (flush) and pc<=branch_target.
  - Clears the buffer.
  - From HOLD, or from FETCH when a response arrives that cycle: go to FETCH of the target next cycle.
  - From FETCH with request pending and no rdy: go to DRAIN with target saved in pc. imem_addr keeps the old address from an internal req_addr register. On rdy, drop the data and go to FETCH at the new pc.
- load_to_stall: IF/ID unchanged, pc unchanged.
  - A response arriving this cycle is written to the buffer (pc+2 recorded); state -> HOLD.
- brstall (no load_to_stall): IF/ID <= bubble, pc unchanged.
  - An arriving response is buffered; state -> HOLD.
- Normal: on transfer, IF/ID <= {1, imem_data, pc+2} and pc<=pc+2.
  - With no transfer, IF/ID <= bubble.
- HOLD exit: first cycle with neither stall asserted, buffer -> IF/ID; state -> FETCH (next request issued the following cycle).
- Buffer: single entry (skid). Cannot overflow, because no request is issued in HOLD.
- HLT:
  - When an instruction with opcode HLT_OPC enters IF/ID, go to HALT and set halted=1.
  - Stays halted until reset, even if later held by load_to_stall.
  - branch_taken in the same cycle as HLT entry wins: no halt (HLT was speculative).
- Arithmetic: pc+2 is modulo 2^PC_W. 16'hFFFE+2 wraps to 16'h0000 with no flag.
- Reset mid-request: abandon immediately. Memory must accept req dropping asynchronously.

Decomposition:
- Shared package holds:
  - opcode constants OPC_B=4'hC, OPC_BR=4'hD, OPC_SW=4'h9, OPC_HLT=4'hF.
  - fetch state enum {FETCH, HOLD, DRAIN, HALT}.
  - field-slice functions for rs/rt.
- One sub-module: if_id_reg (IF/ID flops with hold/bubble/load controls plus hazard-field decode). FSM, PC and buffer stay in fetch_stage.

Test Plan:
- Zero-latency fetch (rdy=1 always), reset released -> imem_addr 0000, 0002, 0004 on consecutive cycles; if_id_pc_plus2 0002, 0004, 0006; if_id_valid=1 from cycle 2.
- 3-cycle latency memory -> imem_addr held at 0000 for 3 cycles; if_id_valid=1 for one cycle in every 4, with bubbles between.
- load_to_stall for 2 cycles coinciding with a response 1234 at pc 0006 -> IF/ID frozen; state HOLD; after release IF/ID=1234, pc_plus2=0008; next request addr 0008.
- Request at 0010 pending, branch_taken with target 0040 -> IF/ID flushed; imem_addr stays 0010 until rdy; that data discarded; next request 0040; no instruction from 0010 reaches IF/ID.
- Opcode C in IF/ID with brstall=1, branch_taken=0 -> next cycle if_id_valid=0, pc unchanged; fetch resumes at branch pc+2.
- Fetch F000 -> halted=1 one cycle after it enters IF/ID; imem_req=0 thereafter. Repeat with branch_taken in the HLT cycle -> halted stays 0 and fetch continues at the target.
